// File: rtl/rgmii_rx_frame_parser_if.sv
// Receive nibble stream in, parsed frame fields and status out.
interface rgmii_rx_frame_parser_if #(
  parameter int CNT_W = 11
);
  logic             rx_dv;
  logic             rx_nib_valid;
  logic [3:0]       rx_d;
  logic [47:0]      dst_mac;
  logic [47:0]      src_mac;
  logic [15:0]      eth_type;
  logic             hdr_valid;
  logic             dst_match;
  logic [7:0]       pl_data;
  logic             pl_valid;
  logic [CNT_W-1:0] pl_count;
  logic             frame_done;
  logic             frame_err;

  modport master (
    output rx_dv, rx_nib_valid, rx_d,
    input  dst_mac, src_mac, eth_type, hdr_valid, dst_match,
           pl_data, pl_valid, pl_count, frame_done, frame_err
  );

  modport slave (
    input  rx_dv, rx_nib_valid, rx_d,
    output dst_mac, src_mac, eth_type, hdr_valid, dst_match,
           pl_data, pl_valid, pl_count, frame_done, frame_err
  );
endinterface

// File: rtl/rgmii_rx_frame_parser.sv
// Ethernet frame parser fed by the RGMII nibble receiver: locks onto
// preamble/SFD, captures the 14-byte header, streams payload bytes and
// reports end-of-frame status.
module rgmii_rx_frame_parser #(
  parameter int          PREAMBLE_MIN = 7,
  parameter logic [47:0] MY_MAC       = 48'h54_ff_01_21_23_24,
  parameter int          CNT_W        = 11
) (
  input logic                    clk,
  input logic                    SW0,
  rgmii_rx_frame_parser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

  state_t           state, next_state;
  logic             accept, eof, sfd_ok, hdr_last;
  logic [3:0]       pre_cnt;
  logic [3:0]       hdr_bytes;
  logic             nib_phase;
  logic [3:0]       nib_hold;
  logic [103:0]     hdr_shift;
  logic [111:0]     hdr_full;
  logic             idle_drop;

  logic [47:0]      dst_mac, src_mac;
  logic [15:0]      eth_type;
  logic             hdr_valid, dst_match;
  logic [7:0]       pl_data;
  logic             pl_valid;
  logic [CNT_W-1:0] pl_count;
  logic             frame_done, frame_err;

  assign accept   = bus.rx_nib_valid && bus.rx_dv;
  assign eof      = !bus.rx_dv && (state != IDLE);
  assign sfd_ok   = (bus.rx_d == 4'hD) && (pre_cnt >= 4'(PREAMBLE_MIN));
  assign hdr_last = nib_phase && (hdr_bytes == 4'd13);
  assign hdr_full = {hdr_shift, bus.rx_d, nib_hold};

  assign bus.dst_mac    = dst_mac;
  assign bus.src_mac    = src_mac;
  assign bus.eth_type   = eth_type;
  assign bus.hdr_valid  = hdr_valid;
  assign bus.dst_match  = dst_match;
  assign bus.pl_data    = pl_data;
  assign bus.pl_valid   = pl_valid;
  assign bus.pl_count   = pl_count;
  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err;

  // State register.
  always_ff @(posedge clk or negedge SW0) begin
    if (!SW0) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; a falling data-valid always wins over a nibble.
  always_comb begin
    next_state = state;
    if (eof) begin
      next_state = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:     next_state = (bus.rx_d == 4'h5) ? PREAMBLE : DROP;
        PREAMBLE: if (bus.rx_d != 4'h5) next_state = sfd_ok ? HEADER : DROP;
        HEADER:   if (hdr_last) next_state = PAYLOAD;
        default:  next_state = state;
      endcase
    end
  end

  // Datapath: nibble pairing, header capture, payload stream, status pulses.
  always_ff @(posedge clk or negedge SW0) begin
    if (!SW0) begin
      pre_cnt    <= '0;
      hdr_bytes  <= '0;
      nib_phase  <= 1'b0;
      nib_hold   <= '0;
      hdr_shift  <= '0;
      idle_drop  <= 1'b0;
      dst_mac    <= '0;
      src_mac    <= '0;
      eth_type   <= '0;
      hdr_valid  <= 1'b0;
      dst_match  <= 1'b0;
      pl_data    <= '0;
      pl_valid   <= 1'b0;
      pl_count   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      hdr_valid  <= 1'b0;
      pl_valid   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (eof) begin
        frame_done <= !((state == DROP) && idle_drop);
        frame_err  <= (state != PAYLOAD) || nib_phase;
        nib_phase  <= 1'b0;
      end else if (accept) begin
        case (state)
          IDLE: begin
            pre_cnt   <= 4'd1;
            nib_phase <= 1'b0;
            idle_drop <= (bus.rx_d != 4'h5);
          end
          PREAMBLE: begin
            if (bus.rx_d == 4'h5) begin
              if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
            end else if (sfd_ok) begin
              pl_count  <= '0;
              hdr_bytes <= '0;
              nib_phase <= 1'b0;
            end
          end
          HEADER: begin
            nib_phase <= !nib_phase;
            if (!nib_phase) begin
              nib_hold <= bus.rx_d;
            end else begin
              hdr_shift <= hdr_full[103:0];
              hdr_bytes <= hdr_bytes + 4'd1;
              if (hdr_last) begin
                dst_mac   <= hdr_full[111:64];
                src_mac   <= hdr_full[63:16];
                eth_type  <= hdr_full[15:0];
                hdr_valid <= 1'b1;
                dst_match <= (hdr_full[111:64] == MY_MAC) || (&hdr_full[111:64]);
              end
            end
          end
          PAYLOAD: begin
            nib_phase <= !nib_phase;
            if (!nib_phase) begin
              nib_hold <= bus.rx_d;
            end else begin
              pl_data  <= {bus.rx_d, nib_hold};
              pl_valid <= 1'b1;
              if (pl_count != '1) pl_count <= pl_count + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/rgmii_rx_frame_parser.md
Name: rgmii_rx_frame_parser

Overview:
- Sits directly downstream of the RGMII nibble receiver, in the `clk` domain.
- Takes a qualified receive nibble stream (data-valid level plus per-nibble strobe) and locks onto preamble and SFD.
- Assembles bytes, captures the Ethernet header (destination MAC, source MAC, EtherType), flags address match, and forwards payload bytes with a running count.
- Reports frame completion and framing errors so the UART/LED logic can consume frame status.

Parameters:
- PREAMBLE_MIN, 7: minimum count of 0x5 preamble nibbles required before SFD.
- MY_MAC, 48'h54_ff_01_21_23_24: station address used for `dst_match`.
- CNT_W, 11: width of the payload byte counter; the counter saturates at all-ones.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- SW0  input  1  reset, asynchronous, active-low.
- rx_dv  input  1  receive data-valid level, already synchronised to `clk`.
- rx_nib_valid  input  1  strobe, one `clk` per received nibble.
- rx_d  input  4  received nibble; `rx_d[0]` is the first bit on the wire.
- dst_mac  output  48  captured destination MAC; first received byte is at [47:40].
- src_mac  output  48  captured source MAC; same byte order.
- eth_type  output  16  captured EtherType; first byte is at [15:8].
- hdr_valid  output  1  one-cycle pulse when all 14 header bytes have been captured.
- dst_match  output  1  valid with `hdr_valid`: `dst_mac` equals MY_MAC or is all ones (broadcast).
- pl_data  output  8  payload byte.
- pl_valid  output  1  one-cycle strobe qualifying `pl_data`.
- pl_count  output  CNT_W  payload bytes accepted in the current or last frame.
- frame_done  output  1  one-cycle pulse at end of frame.
- frame_err  output  1  one-cycle pulse, coincident with `frame_done` or the drop event.

Behaviour:
- Reset: all outputs are 0; state is IDLE; counters and the nibble holding register are cleared.
  - Assertion mid-frame aborts immediately, with no `frame_done`.
- Nibble accept: a nibble is accepted only when `rx_nib_valid && rx_dv`.
- Byte assembly: byte = {second nibble, first nibble}, i.e. the low nibble arrives first.
- State IDLE:
  - accepted 0x5 → PREAMBLE, preamble count = 1.
  - any other accepted nibble → DROP.
- State PREAMBLE:
  - 0x5 → count+1, saturating at 15.
  - 0xD with count ≥ PREAMBLE_MIN → HEADER.
  - 0xD with count < PREAMBLE_MIN → DROP.
  - any other value → DROP.
- State HEADER:
  - 28 nibbles are shifted into dst/src/type registers.
  - `dst_mac`, `src_mac` and `eth_type` update only at header completion; they hold their previous values otherwise.
  - `hdr_valid` and `dst_match` assert on the clk after the 28th nibble is accepted; `dst_match` then holds its value until the next `hdr_valid`.
  - Next state: PAYLOAD.
- State PAYLOAD:
  - each second nibble produces `pl_valid` on the following clk, with `pl_data` = assembled byte.
  - `pl_count` increments with each `pl_valid` and saturates at 2^CNT_W−1.
  - `pl_count` clears on SFD acceptance and holds its value after frame end.
- State DROP: nibbles are ignored; no `hdr_valid` or `pl_valid` is produced.
- End of frame: `rx_dv` sampled low in any non-IDLE state produces, on the next clk, a `frame_done` pulse and a return to IDLE.
  - `frame_err` = 1 if the state was PREAMBLE, HEADER or DROP.
  - `frame_err` = 1 if the state was PAYLOAD with an odd nibble pending; the pending partial byte is discarded.
  - `frame_err` = 0 for a PAYLOAD frame ending on a byte boundary.
  - Exception: DROP entered from IDLE on a non-preamble nibble gives `frame_done` = 0 and `frame_err` = 1.
- `rx_dv` low in IDLE: no pulses.
- Simultaneous `rx_dv` fall and `rx_nib_valid`: the nibble is not accepted; the end of frame takes priority.
- Back-to-back frames: a new frame may start on the clk after `frame_done`; one idle `rx_dv`-low cycle is sufficient.

Test Plan:
- Nominal frame: 15×0x5, 0xD, dst 54:ff:01:21:23:24, src 12:34:56:78:9a:bc, type 0x0800, payload 01 02 03 04, then `rx_dv` low → required response:
  - `hdr_valid` pulse with `dst_match`=1, `src_mac`=48'h123456789abc, `eth_type`=16'h0800;
  - `pl_data` sequence 01,02,03,04;
  - `pl_count`=4;
  - `frame_done`=1, `frame_err`=0.
- Broadcast and miss: dst ff:ff:ff:ff:ff:ff → `dst_match`=1; dst 00:11:22:33:44:55 → `dst_match`=0; header still captured in both cases.
- Short preamble: 5×0x5 then 0xD, then header → no `hdr_valid`, no `pl_valid`; on `rx_dv` fall, `frame_done`=1 and `frame_err`=1.
- Truncated header: `rx_dv` drops after 10 header nibbles → no `hdr_valid`; `frame_done`=1, `frame_err`=1; `dst_mac` retains the prior frame's value.
- Odd nibble: payload 0xA5 followed by one extra nibble, then `rx_dv` low → one `pl_valid` with 0xA5, `pl_count`=1, `frame_err`=1.
- Reset mid-payload: `SW0` low for 1 clk after 2 payload bytes → all outputs 0 immediately, no `frame_done`; the next nominal frame parses correctly.
